// File: rtl/koder_arbitar.sv
// Round-robin arbiter/sequencer sharing one parity coder between a 40-bit (A) and a 12-bit (B) requester.
// Optional build macro KODER_ODD_PARITY_EN selects odd parity; the default build uses even parity.
//
// state  | meaning
// S_IDLE | waiting for a request; winner's ready is driven combinationally
// S_CODE | parity computed over the captured word, frame registered
// S_HOLD | frame presented on out_valid until out_ready
module koder_arbitar #(
  parameter int A_W   = 40,
  parameter int B_W   = 12,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_a_valid,
  input  logic [A_W-1:0]   i_a_data,
  output logic             o_a_ready,
  input  logic             i_b_valid,
  input  logic [B_W-1:0]   i_b_data,
  output logic             o_b_ready,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [A_W:0]     o_out_frame,
  output logic             o_out_src,
  output logic [CNT_W-1:0] o_cnt_a,
  output logic [CNT_W-1:0] o_cnt_b
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CODE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last_b;
  logic [A_W-1:0]   r_word;
  logic             r_word_src;
  logic             r_out_valid;
  logic [A_W:0]     r_out_frame;
  logic             r_out_src;
  logic [CNT_W-1:0] r_cnt_a;
  logic [CNT_W-1:0] r_cnt_b;

  logic w_idle;
  logic w_pick_b;
  logic w_grant_a;
  logic w_grant_b;

  function automatic logic f_par_a(input logic [A_W-1:0] d);
`ifdef KODER_ODD_PARITY_EN
    return ~^d;
`else
    return ^d;
`endif
  endfunction

  function automatic logic f_par_b(input logic [B_W-1:0] d);
`ifdef KODER_ODD_PARITY_EN
    return ~^d;
`else
    return ^d;
`endif
  endfunction

  // Ready is gated by reset so an asserted reset clears every output at once.
  always_comb begin
    w_idle    = (r_state == S_IDLE) && !i_rst;
    w_pick_b  = i_b_valid && (!i_a_valid || !r_last_b);
    w_grant_b = w_idle && w_pick_b;
    w_grant_a = w_idle && i_a_valid && !w_pick_b;
  end

  assign o_a_ready   = w_grant_a;
  assign o_b_ready   = w_grant_b;
  assign o_out_valid = r_out_valid;
  assign o_out_frame = r_out_frame;
  assign o_out_src   = r_out_src;
  assign o_cnt_a     = r_cnt_a;
  assign o_cnt_b     = r_cnt_b;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_last_b    <= 1'b1;
      r_word      <= '0;
      r_word_src  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_frame <= '0;
      r_out_src   <= 1'b0;
      r_cnt_a     <= '0;
      r_cnt_b     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_a) begin
            r_word     <= i_a_data;
            r_word_src <= 1'b0;
            r_last_b   <= 1'b0;
            r_state    <= S_CODE;
          end else if (w_grant_b) begin
            r_word     <= {{(A_W-B_W){1'b0}}, i_b_data};
            r_word_src <= 1'b1;
            r_last_b   <= 1'b1;
            r_state    <= S_CODE;
          end
        end
        S_CODE: begin
          if (r_word_src) begin
            r_out_frame <= {{(A_W-B_W){1'b0}}, f_par_b(r_word[B_W-1:0]), r_word[B_W-1:0]};
          end else begin
            r_out_frame <= {f_par_a(r_word), r_word};
          end
          r_out_src   <= r_word_src;
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_out_src) r_cnt_b <= r_cnt_b + CNT_W'(1);
            else           r_cnt_a <= r_cnt_a + CNT_W'(1);
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_koder_arbitar.sv
// Scoreboard bench for koder_arbitar: frames expected at grant time are compared when presented.
// Honours KODER_ODD_PARITY_EN for the expected parity.
module tb_koder_arbitar;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid;
  logic [39:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [11:0] b_data;
  logic        b_ready;
  logic        out_valid;
  logic        out_ready;
  logic [40:0] out_frame;
  logic        out_src;
  logic [7:0]  cnt_a;
  logic [7:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  logic [41:0] exp_q[$];
  logic [7:0]  exp_cnt_a;
  logic [7:0]  exp_cnt_b;

`ifdef KODER_ODD_PARITY_EN
  localparam logic [40:0] T1_FRAME = 41'h0646a6f6c65;
  localparam logic [40:0] T2_FRAME = 41'h00000001648;
`else
  localparam logic [40:0] T1_FRAME = 41'h1646a6f6c65;
  localparam logic [40:0] T2_FRAME = 41'h00000000648;
`endif

  koder_arbitar dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_a_valid   (a_valid),
    .i_a_data    (a_data),
    .o_a_ready   (a_ready),
    .i_b_valid   (b_valid),
    .i_b_data    (b_data),
    .o_b_ready   (b_ready),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_frame (out_frame),
    .o_out_src   (out_src),
    .o_cnt_a     (cnt_a),
    .o_cnt_b     (cnt_b)
  );

  always #5 clk = ~clk;

  function automatic logic [41:0] model_a(input logic [39:0] d);
    logic p;
    p = ^d;
`ifdef KODER_ODD_PARITY_EN
    p = ~p;
`endif
    return {1'b0, p, d};
  endfunction

  function automatic logic [41:0] model_b(input logic [11:0] d);
    logic p;
    p = ^d;
`ifdef KODER_ODD_PARITY_EN
    p = ~p;
`endif
    return {1'b1, 28'b0, p, d};
  endfunction

  function automatic logic [39:0] rand_a();
    return {8'($urandom), 32'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b0;
    a_data = 40'h0; b_data = 12'h0;
    #12;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready: got %b want 0", b_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_frame !== 41'h0) begin errors++; $display("FAIL reset_out_frame: got %h want 0", out_frame); end
    checks++; if (out_src !== 1'b0) begin errors++; $display("FAIL reset_out_src: got %b want 0", out_src); end
    checks++; if (cnt_a !== 8'h0 || cnt_b !== 8'h0) begin errors++; $display("FAIL reset_cnt: got %h/%h want 0/0", cnt_a, cnt_b); end
    a_valid = 1'b0; b_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_cnt_a = 8'h0; exp_cnt_b = 8'h0; exp_q.delete();
  endtask

  task automatic test_single_a();
    logic [41:0] e;
    @(negedge clk);
    a_valid = 1'b1; a_data = 40'h646a6f6c65; out_ready = 1'b1; #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL single_a_ready: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    exp_q.push_back(model_a(a_data));
    @(negedge clk);
    a_valid = 1'b0; a_data = 40'hffffffffff;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_a_t1: out_valid got %b want 0", out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_a_t2: out_valid got %b want 1", out_valid); end
    e = exp_q.pop_front();
    checks++; if ({out_src, out_frame} !== e) begin errors++; $display("FAIL single_a_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
    checks++; if (out_frame !== T1_FRAME) begin errors++; $display("FAIL single_a_literal: got %h want %h", out_frame, T1_FRAME); end
    exp_cnt_a++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_a_drop: out_valid got %b want 0", out_valid); end
    checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL single_a_cnt: got %0d want %0d", cnt_a, exp_cnt_a); end
  endtask

  task automatic test_single_b();
    logic [41:0] e;
    b_valid = 1'b1; b_data = 12'b011001001000; #1;
    checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL single_b_ready: got a=%b b=%b want a=0 b=1", a_ready, b_ready); end
    exp_q.push_back(model_b(b_data));
    @(negedge clk);
    b_valid = 1'b0; b_data = 12'hfff;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_b_t2: out_valid got %b want 1", out_valid); end
    e = exp_q.pop_front();
    checks++; if ({out_src, out_frame} !== e) begin errors++; $display("FAIL single_b_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
    checks++; if (out_frame !== T2_FRAME || out_src !== 1'b1) begin errors++; $display("FAIL single_b_literal: got %b/%h want 1/%h", out_src, out_frame, T2_FRAME); end
    exp_cnt_b++;
    @(negedge clk);
    checks++; if (cnt_b !== exp_cnt_b) begin errors++; $display("FAIL single_b_cnt: got %0d want %0d", cnt_b, exp_cnt_b); end
  endtask

  task automatic test_back_to_back();
    int   due_q[$];
    int   ngrants = 0;
    int   last_c = 0;
    logic want_b = 1'b0;
    logic [41:0] e;
    logic got;
    a_valid = 1'b1; b_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      a_data = rand_a(); b_data = 12'($urandom); #1;
      checks++; if (a_ready && b_ready) begin errors++; $display("FAIL b2b_both_ready: cycle %0d", c); end
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_extra_frame: got %h want none", out_frame); end
        else begin
          e = exp_q.pop_front();
          if ({out_src, out_frame} !== e || c != due_q.pop_front()) begin
            errors++; $display("FAIL b2b_frame: cycle %0d got %b/%h want %b/%h", c, out_src, out_frame, e[41], e[40:0]);
          end
          if (e[41]) exp_cnt_b++; else exp_cnt_a++;
        end
      end
      if (a_ready || b_ready) begin
        checks++; if (b_ready !== want_b) begin errors++; $display("FAIL b2b_order: grant %0d got src %b want %b", ngrants, b_ready, want_b); end
        if (ngrants > 0) begin
          checks++; if (c - last_c != 3) begin errors++; $display("FAIL b2b_spacing: got %0d want 3", c - last_c); end
        end
        exp_q.push_back(b_ready ? model_b(b_data) : model_a(a_data));
        due_q.push_back(c + 2);
        want_b = ~b_ready; last_c = c; ngrants++;
      end
      @(negedge clk);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        e = exp_q.pop_front();
        checks++; if ({out_src, out_frame} !== e) begin errors++; $display("FAIL b2b_last_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
        if (e[41]) exp_cnt_b++; else exp_cnt_a++;
      end
      @(negedge clk);
    end
    if (!got) begin checks++; errors++; $display("FAIL b2b_timeout: got no frame want one"); end
    checks++; if (ngrants != 6) begin errors++; $display("FAIL b2b_grants: got %0d want 6", ngrants); end
    checks++; if (cnt_a !== exp_cnt_a || cnt_b !== exp_cnt_b) begin errors++; $display("FAIL b2b_cnt: got %0d/%0d want %0d/%0d", cnt_a, cnt_b, exp_cnt_a, exp_cnt_b); end
  endtask

  task automatic test_hold_stall();
    logic [41:0] e;
    logic got;
    out_ready = 1'b0; a_valid = 1'b1; a_data = rand_a(); #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL stall_grant: a_ready got %b want 1", a_ready); end
    exp_q.push_back(model_a(a_data));
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b1; b_data = 12'($urandom);
    @(negedge clk);
    e = exp_q.pop_front();
    for (int k = 0; k < 11; k++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || {out_src, out_frame} !== e || a_ready !== 1'b0 || b_ready !== 1'b0 || cnt_a !== exp_cnt_a) begin
        errors++; $display("FAIL stall_hold: cycle %0d got v=%b f=%h ar=%b br=%b cnt=%0d want v=1 f=%h ar=0 br=0 cnt=%0d",
                           k, out_valid, out_frame, a_ready, b_ready, cnt_a, e[40:0], exp_cnt_a);
      end
      @(negedge clk);
    end
    out_ready = 1'b1; exp_cnt_a++;
    @(negedge clk); #1;
    checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL stall_cnt: got %0d want %0d", cnt_a, exp_cnt_a); end
    checks++; if (b_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_next_grant: got br=%b v=%b want br=1 v=0", b_ready, out_valid); end
    exp_q.push_back(model_b(b_data));
    @(negedge clk);
    b_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        e = exp_q.pop_front();
        checks++; if ({out_src, out_frame} !== e) begin errors++; $display("FAIL stall_b_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
        exp_cnt_b++;
      end
      @(negedge clk);
    end
    if (!got) begin checks++; errors++; $display("FAIL stall_timeout: got no frame want one"); end
  endtask

  task automatic test_reset_mid();
    logic [41:0] e;
    logic got;
    a_valid = 1'b1; a_data = rand_a(); out_ready = 1'b1; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_grant: a_ready got %b want 1", a_ready); end
    @(negedge clk);
    a_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_frame !== 41'h0 || out_src !== 1'b0 || a_ready !== 1'b0 || b_ready !== 1'b0 || cnt_a !== 8'h0 || cnt_b !== 8'h0) begin
      errors++; $display("FAIL midrst_outputs: got v=%b f=%h s=%b ar=%b br=%b ca=%0d cb=%0d want all 0",
                         out_valid, out_frame, out_src, a_ready, b_ready, cnt_a, cnt_b);
    end
    exp_cnt_a = 8'h0; exp_cnt_b = 8'h0;
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_frame: cycle %0d out_valid got %b want 0", k, out_valid); end
      @(negedge clk);
    end
    a_valid = 1'b1; b_valid = 1'b1; a_data = rand_a(); b_data = 12'($urandom); #1;
    checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin errors++; $display("FAIL midrst_first_win: got a=%b b=%b want a=1 b=0", a_ready, b_ready); end
    exp_q.push_back(model_a(a_data));
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (out_valid) begin
        got = 1'b1;
        e = exp_q.pop_front();
        checks++; if ({out_src, out_frame} !== e) begin errors++; $display("FAIL midrst_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
        exp_cnt_a++;
      end
      @(negedge clk);
    end
    if (!got) begin checks++; errors++; $display("FAIL midrst_timeout: got no frame want one"); end
    checks++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL midrst_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_counter_wrap();
    int delivered = 0;
    logic saw_255 = 1'b0;
    logic [41:0] e;
    a_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 1200 && delivered < 255; c++) begin
      a_data = rand_a(); #1;
      checks++; if (cnt_a !== exp_cnt_a) begin errors++; $display("FAIL wrap_cnt_track: got %0d want %0d", cnt_a, exp_cnt_a); end
      if (cnt_a === 8'd255) saw_255 = 1'b1;
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL wrap_extra_frame: got %h want none", out_frame); end
        else begin
          e = exp_q.pop_front();
          if ({out_src, out_frame} !== e) begin errors++; $display("FAIL wrap_frame: got %b/%h want %b/%h", out_src, out_frame, e[41], e[40:0]); end
        end
        exp_cnt_a++; delivered++;
      end
      if (a_ready) exp_q.push_back(model_a(a_data));
      @(negedge clk);
    end
    a_valid = 1'b0; #1;
    checks++; if (delivered != 255) begin errors++; $display("FAIL wrap_timeout: got %0d frames want 255", delivered); end
    checks++; if (saw_255 !== 1'b1) begin errors++; $display("FAIL wrap_reach_255: cnt_a never showed 255"); end
    checks++; if (cnt_a !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0d want 0", cnt_a); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_pending: got %0d frames outstanding want 0", exp_q.size()); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_single_b();
    test_back_to_back();
    test_hold_stall();
    test_reset_mid();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
